// File: rtl/uart_rx_monitor.sv
// Drains a show-ahead UART RX FIFO one byte per two cycles, counts bytes and
// matches, and shows the last byte / byte count on a 4-digit seven-segment display.
module uart_rx_monitor #(
  parameter int         REFRESH_N  = 18,
  parameter logic [7:0] MATCH_BYTE = 8'h33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] last_byte,
  output logic [7:0] byte_cnt,
  output logic [7:0] match_cnt,
  output logic       match_tick,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic [7:0] led
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t               state;
  logic [REFRESH_N-1:0] refresh;
  logic [1:0]           sel;
  logic [3:0]           digit;
  logic                 dp;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // The GAP state gives the FIFO one cycle to advance its head after a pop.
  assign rd_uart = (state == IDLE) && !rx_empty;
  assign led     = last_byte;

  // Read FSM with byte/match bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_byte  <= 8'h00;
      byte_cnt   <= 8'h00;
      match_cnt  <= 8'h00;
      match_tick <= 1'b0;
    end else begin
      match_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_uart) begin
            last_byte <= r_data;
            byte_cnt  <= byte_cnt + 8'd1;
            if (r_data == MATCH_BYTE) begin
              match_tick <= 1'b1;
              if (match_cnt != 8'hFF) begin
                match_cnt <= match_cnt + 8'd1;
              end else begin
                match_cnt <= match_cnt;
              end
            end else begin
              match_tick <= 1'b0;
            end
            state <= GAP;
          end else begin
            state <= IDLE;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running display refresh counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh <= '0;
    end else begin
      refresh <= refresh + {{(REFRESH_N-1){1'b0}}, 1'b1};
    end
  end

  assign sel = refresh[REFRESH_N-1:REFRESH_N-2];

  // Digit multiplexer
  always_comb begin
    an    = 4'b1111;
    digit = 4'h0;
    case (sel)
      2'd0: begin an = 4'b1110; digit = last_byte[3:0]; end
      2'd1: begin an = 4'b1101; digit = last_byte[7:4]; end
      2'd2: begin an = 4'b1011; digit = byte_cnt[3:0];  end
      2'd3: begin an = 4'b0111; digit = byte_cnt[7:4];  end
      default: begin an = 4'b1111; digit = 4'h0; end
    endcase
  end

  assign dp   = !((sel == 2'd0) && (match_cnt != 8'h00));
  assign sseg = {dp, hex7(digit)};

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Receive-side companion to the UART loopback test top. It drains the UART receive FIFO through the `rx_empty`/`rd_uart`/`r_data` read handshake and latches each byte. It counts received bytes and bytes that equal a programmable match value. It drives the 4-digit multiplexed seven-segment display and the LEDs with that status. It sits beside the `uart` instance and takes ownership of `rd_uart`, which the test top currently ties low.

## Interface
- `REFRESH_N`, default 18: width of the display refresh counter; each digit is shown for 2^(REFRESH_N-2) cycles.
- `MATCH_BYTE`, default 8'h33: byte value counted as a match.
- `clk`  in  1  system clock; only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_empty`  in  1  UART RX FIFO empty; `r_data` is valid whenever this is 0 (show-ahead FIFO).
- `r_data`  in  8  head byte of the UART RX FIFO.
- `rd_uart`  out  1  one-cycle pop strobe to the RX FIFO.
- `last_byte`  out  8  most recently consumed byte.
- `byte_cnt`  out  8  bytes consumed, modulo 256.
- `match_cnt`  out  8  bytes equal to MATCH_BYTE, saturating.
- `match_tick`  out  1  one-cycle pulse per matching byte.
- `an`  out  4  digit enables, active low.
- `sseg`  out  8  {dp, g, f, e, d, c, b, a}, all active low.
- `led`  out  8  equals `last_byte`.

## Operation
- **Read FSM**, two states:
  - IDLE: `rd_uart` = (state==IDLE && !rx_empty), combinational. On a cycle where `rd_uart`=1, at the same edge:
    - `last_byte` <= `r_data`
    - `byte_cnt` <= `byte_cnt` + 1, wrapping 0xFF->0x00
    - if `r_data`==MATCH_BYTE: `match_cnt` <= `match_cnt` + 1 unless already 0xFF, and `match_tick` <= 1
    - next state GAP
  - GAP: `rd_uart`=0 for exactly one cycle so the FIFO's `rx_empty`/`r_data` reflect the pop. Then back to IDLE unconditionally.
- Throughput is at most one byte per 2 cycles. Bytes are never dropped or double-read.
- `match_tick` is registered: high for exactly the cycle after the pop edge, otherwise 0.
- **Display**: `refresh` counter, REFRESH_N bits, free-running and wrapping. `sel` = `refresh`[REFRESH_N-1:REFRESH_N-2].
  - sel 0: `an`=1110, `last_byte`[3:0]
  - sel 1: `an`=1101, `last_byte`[7:4]
  - sel 2: `an`=1011, `byte_cnt`[3:0]
  - sel 3: `an`=0111, `byte_cnt`[7:4]
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp (`sseg`[7]) is 0 only when sel==0 and `match_cnt`!=0; otherwise 1.
- `an`/`sseg` are combinational from registered state; no extra pipeline stage.

## Timing
- **Reset** (async, immediate):
  - state IDLE, `last_byte`=0, `byte_cnt`=0, `match_cnt`=0, `match_tick`=0, `refresh`=0.
  - Outputs therefore read `an`=1110, `sseg`=8'hC0, `led`=0.
  - `rd_uart` = !`rx_empty` during and after reset; it is gated by state, and the pop only takes effect after reset releases because the FIFO is reset too.
- **Latency**: `r_data` visible with `rx_empty`=0 in cycle N (state IDLE) -> `rd_uart`=1 in cycle N. `last_byte`/`byte_cnt` update at the end of N. `match_tick`=1 in N+1. Display shows the new value from N+1 when the relevant digit is selected.
- **Back-to-back**: FIFO non-empty continuously -> pops in cycles N, N+2, N+4, …
- **Reset mid-operation**: a reset asserted in GAP returns to IDLE. The counters clear and no partial update survives.
- **Saturation**: at `match_cnt`=0xFF, a further match still pulses `match_tick` and increments `byte_cnt`, but `match_cnt` holds 0xFF.
- **Wrap**: `byte_cnt` 0xFF + one byte -> 0x00. This has no effect on `match_cnt`.

## Test plan
1. **Reset**: assert `reset`, `rx_empty`=1 -> `an`=1110, `sseg`=8'hC0, `led`=0, `byte_cnt`=`match_cnt`=0, `rd_uart`=0.
2. **Single byte**: FIFO model with one byte 0x5A -> exactly one `rd_uart` pulse, `last_byte`=0x5A, `byte_cnt`=1, `match_cnt`=0, no `match_tick`.
3. **Burst with match**: FIFO preloaded 0x33, 0x10, 0x33 -> `rd_uart` high in cycles N, N+2, N+4; `last_byte`=0x33; `byte_cnt`=3; `match_cnt`=2; `match_tick` pulses at N+1 and N+5.
4. **Wrap and saturate**: push 256 bytes of 0x33 -> `byte_cnt`=0x00, `match_cnt`=0xFF. Then push 2 more 0x33 -> `byte_cnt`=2, `match_cnt`=0xFF, 2 more `match_tick` pulses.
5. **Display scan** (REFRESH_N=4): `last_byte`=0xA7, `byte_cnt`=0x1C, `match_cnt`=1 -> every 4 cycles `an` steps 1110/1101/1011/0111 with `sseg` = 0x78 (7 with dp lit), 0x88 (A), 0xC6 (C), 0xF9 (1).
6. **Reset during GAP**: assert `reset` in the cycle after a pop -> all registers cleared immediately. After release, the next non-empty FIFO byte is popped once and `byte_cnt`=1.
